// File: rtl/eq_band_mixer.sv
// Sequential band mixer: sums NUM_BANDS captured bands one per cycle, applies master volume, saturates to 16b.
// Optional clip counter (clr_clip / clip_cnt) is present when EQ_MIX_CLIP_CNT_EN is defined.
module eq_band_mixer #(
    parameter int unsigned NUM_BANDS = 5,
    parameter int unsigned VOL_W     = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seq_valid,
    input  logic [16*NUM_BANDS-1:0]   band_in,
    input  logic [VOL_W-1:0]          VOLUME,
`ifdef EQ_MIX_CLIP_CNT_EN
    input  logic                      clr_clip,
    output logic [7:0]                clip_cnt,
`endif
    output logic [15:0]               aud_out,
    output logic                      aud_vld,
    output logic                      busy
);

    localparam int unsigned ACC_W  = 19;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BAND_W = 16 * NUM_BANDS;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SCALE
    } state_e;

    state_e                    state_q;
    logic [BAND_W-1:0]         bands_q;
    logic [VOL_W-1:0]          vol_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [15:0]               aud_out_q;
    logic                      aud_vld_q;
    logic                      busy_q;

    logic signed [ACC_W-1:0]   band_ext_c;
    logic signed [ACC_W-1:0]   acc_sum_c;
    logic signed [31:0]        shift_c;
    logic [15:0]               sat_c;

    // Current band is always the low slice; the holding register shifts down each ACC cycle.
    always_comb begin
        band_ext_c = {{(ACC_W-16){bands_q[15]}}, bands_q[15:0]};
        acc_sum_c  = acc_q + band_ext_c;
        shift_c    = ($signed(32'(acc_q)) * $signed(32'({1'b0, vol_q}))) >>> 11;
        sat_c      = shift_c[15:0];
        if (shift_c > 32'sd32767) begin
            sat_c = 16'h7FFF;
        end else if (shift_c < -32'sd32768) begin
            sat_c = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bands_q   <= '0;
            vol_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            aud_out_q <= '0;
            aud_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            aud_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seq_valid) begin
                        bands_q <= band_in;
                        vol_q   <= VOLUME;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q   <= acc_sum_c;
                    bands_q <= bands_q >> 16;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == IDX_W'(NUM_BANDS - 1)) begin
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    aud_out_q <= sat_c;
                    aud_vld_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EQ_MIX_CLIP_CNT_EN
    logic       clip_c;
    logic [7:0] clip_cnt_q;

    assign clip_c = (shift_c > 32'sd32767) || (shift_c < -32'sd32768);

    // Saturating count of clipped output samples; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else if (clr_clip) begin
            clip_cnt_q <= '0;
        end else if (state_q == SCALE && clip_c && clip_cnt_q != 8'hFF) begin
            clip_cnt_q <= clip_cnt_q + 8'd1;
        end
    end

    assign clip_cnt = clip_cnt_q;
`endif

    assign aud_out = aud_out_q;
    assign aud_vld = aud_vld_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Randomized self-checking bench for eq_band_mixer against an arithmetic reference of the mix rules.
module tb_eq_band_mixer;

    localparam int unsigned NB    = 5;
    localparam int unsigned VOL_W = 12;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                seq_valid;
    logic [16*NB-1:0]    band_in;
    logic [VOL_W-1:0]    VOLUME;
    logic [15:0]         aud_out;
    logic                aud_vld;
    logic                busy;
`ifdef EQ_MIX_CLIP_CNT_EN
    logic                clr_clip;
    logic [7:0]          clip_cnt;
    int                  exp_clip = 0;
`endif

    int n_vec = 0;
    int n_err = 0;

    eq_band_mixer #(.NUM_BANDS(NB), .VOL_W(VOL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seq_valid (seq_valid),
        .band_in   (band_in),
        .VOLUME    (VOLUME),
`ifdef EQ_MIX_CLIP_CNT_EN
        .clr_clip  (clr_clip),
        .clip_cnt  (clip_cnt),
`endif
        .aud_out   (aud_out),
        .aud_vld   (aud_vld),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Unclamped mix result: floor((sum of bands) * volume / 2048).
    function automatic longint mix_raw(input logic [16*NB-1:0] b, input logic [VOL_W-1:0] v);
        longint s = 0;
        logic [15:0] w;
        for (int k = 0; k < int'(NB); k++) begin
            w = b[16*k +: 16];
            s += longint'($signed(w));
        end
        return (s * longint'(v)) >>> 11;
    endfunction

    function automatic logic [15:0] mix_model(input logic [16*NB-1:0] b, input logic [VOL_W-1:0] v);
        longint r = mix_raw(b, v);
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return 16'(r);
    endfunction

    function automatic logic [16*NB-1:0] all_bands(input logic [15:0] val);
        logic [16*NB-1:0] b;
        for (int k = 0; k < int'(NB); k++) b[16*k +: 16] = val;
        return b;
    endfunction

    // One full mix: capture, walk the pipeline (optionally disturbing inputs), check result and timing.
    task automatic run_mix(input string tag, input logic [16*NB-1:0] b, input logic [VOL_W-1:0] v, input bit noise);
        int edges = 0;
        int busy_cnt = 0;
        longint r;
        @(negedge clk);
        seq_valid = 1'b1;
        band_in   = b;
        VOLUME    = v;
        @(posedge clk); #1;
        seq_valid = 1'b0;
        while (!aud_vld && edges < 20) begin
            busy_cnt += int'(busy);
            if (noise) begin
                for (int k = 0; k < int'(NB); k++) band_in[16*k +: 16] = 16'($urandom);
                VOLUME    = VOL_W'($urandom);
                seq_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            edges++;
        end
        seq_valid = 1'b0;
        chk({tag, "_lat"}, 32'(edges), 32'(NB + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(NB + 1));
        chk({tag, "_busy_in_vld"}, 32'(busy), 32'd0);
        chk({tag, "_out"}, 32'(aud_out), 32'(mix_model(b, v)));
`ifdef EQ_MIX_CLIP_CNT_EN
        r = mix_raw(b, v);
        if ((r > 32767 || r < -32768) && exp_clip < 255) exp_clip++;
        chk({tag, "_clip"}, 32'(clip_cnt), 32'(exp_clip));
`else
        r = 0;
`endif
    endtask

    initial begin
        logic [16*NB-1:0] b;
        logic [15:0]      last_out;
        int               vcnt;
        rst_n     = 1'b0;
        seq_valid = 1'($urandom_range(0, 1));
        for (int k = 0; k < int'(NB); k++) band_in[16*k +: 16] = 16'($urandom);
        VOLUME    = VOL_W'($urandom);
`ifdef EQ_MIX_CLIP_CNT_EN
        clr_clip  = 1'b0;
`endif
        #23;
        chk("rst_out", 32'(aud_out), 32'd0);
        chk("rst_vld", 32'(aud_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef EQ_MIX_CLIP_CNT_EN
        chk("rst_clip", 32'(clip_cnt), 32'd0);
`endif
        @(negedge clk);
        seq_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        run_mix("unity", all_bands(16'h1000), 12'h800, 1'b0);
        @(posedge clk); #1;
        chk("unity_pulse_single", 32'(aud_vld), 32'd0);
        chk("unity_out_hold", 32'(aud_out), 32'h5000);

        run_mix("sat_pos", all_bands(16'h7FFF), 12'h800, 1'b0);
        run_mix("sat_neg", all_bands(16'h8000), 12'h800, 1'b0);

        b = '0;
        b[15:0] = 16'h0100;
        run_mix("vol_max", b, 12'hFFF, 1'b0);
        run_mix("vol_zero", b, 12'h000, 1'b0);

`ifdef EQ_MIX_CLIP_CNT_EN
        @(negedge clk);
        clr_clip = 1'b1;
        @(negedge clk);
        clr_clip = 1'b0;
        exp_clip = 0;
        chk("clip_clear", 32'(clip_cnt), 32'd0);
`endif

        // Random sets, back-to-back, with inputs disturbed during the mix.
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < int'(NB); k++) begin
                case ($urandom_range(0, 3))
                    0:       b[16*k +: 16] = 16'h7FFF;
                    1:       b[16*k +: 16] = 16'h8000;
                    default: b[16*k +: 16] = 16'($urandom);
                endcase
            end
            run_mix("rand", b, VOL_W'($urandom), 1'($urandom_range(0, 1)));
        end

        // seq_valid held high: one result every NB+2 edges, busy-time requests dropped.
        @(negedge clk);
        seq_valid = 1'b1;
        band_in   = all_bands(16'h0001);
        VOLUME    = 12'h800;
        vcnt = 0;
        for (int k = 0; k < 4 * int'(NB + 2); k++) begin
            @(posedge clk); #1;
            chk("stream_vld", 32'(aud_vld), 32'((k % int'(NB + 2)) == int'(NB + 1)));
            if (aud_vld) begin
                vcnt++;
                chk("stream_out", 32'(aud_out), 32'h0005);
            end
        end
        seq_valid = 1'b0;
        chk("stream_count", 32'(vcnt), 32'd4);

        // Reset during the third ACC cycle aborts the mix.
        @(negedge clk);
        seq_valid = 1'b1;
        band_in   = all_bands(16'h0123);
        VOLUME    = 12'h800;
        @(posedge clk); #1;
        seq_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(aud_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vld", 32'(aud_vld), 32'd0);
`ifdef EQ_MIX_CLIP_CNT_EN
        exp_clip = 0;
        chk("abort_clip", 32'(clip_cnt), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            vcnt += int'(aud_vld);
        end
        chk("abort_no_vld", 32'(vcnt), 32'd0);
        last_out = aud_out;
        chk("abort_out_held", 32'(last_out), 32'd0);
        b = all_bands(16'hF000);
        run_mix("after_abort", b, 12'h400, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
